// File: rtl/seven_seg_pkg.sv
// Shared constants, state encoding and BCD helpers for the
// seven-segment pair to binary converter.
package seven_seg_pkg;

  localparam int SEG_W   = 7;
  localparam int BCD_W   = 8;
  localparam int BIN_W   = 7;
  localparam int CNT_MAX = 63;
  localparam int DD_W    = BCD_W + BIN_W;
  localparam int ITERS   = BIN_W;
  localparam int ITER_W  = 3;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] DIG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] DIG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] DIG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] DIG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] DIG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] DIG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] DIG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] DIG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] DIG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] DIG_9 = 7'b0010000;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    CONVERT,
    DONE
  } state_t;

  typedef logic [DD_W-1:0] dd_t;

  // One reverse double-dabble step: shift right, then
  // pull every BCD nibble that reads >= 8 back by 3.
  function automatic dd_t dabble_step(input dd_t v);
    dd_t s;
    logic [3:0] nib;
    s = v >> 1;
    for (int i = 0; i < BCD_W / 4; i++) begin
      nib = s[BIN_W + 4*i +: 4];
      if (nib >= 4'd8) begin
        s[BIN_W + 4*i +: 4] = nib - 4'd3;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/seven_segments_to_binary_decoder.sv
// Combinational map of one active-low 7-segment pattern
// to a BCD digit, flagging patterns that are not digits.
module seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       digit,
  output logic             legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    unique case (1'b1)
      (pattern == DIG_0): digit = 4'd0;
      (pattern == DIG_1): digit = 4'd1;
      (pattern == DIG_2): digit = 4'd2;
      (pattern == DIG_3): digit = 4'd3;
      (pattern == DIG_4): digit = 4'd4;
      (pattern == DIG_5): digit = 4'd5;
      (pattern == DIG_6): digit = 4'd6;
      (pattern == DIG_7): digit = 4'd7;
      (pattern == DIG_8): digit = 4'd8;
      (pattern == DIG_9): digit = 4'd9;
      default:            legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segments_to_binary.sv
// Two-digit seven-segment to binary converter, fixed 9-cycle latency.
// Define SEG_ACTIVE_HIGH_EN for active-high segment inputs.
module seven_segments_to_binary
  import seven_seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEG_W-1:0] seg_ones,
  input  logic [SEG_W-1:0] seg_tens,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] bin,
  output logic             err,
  output logic             ovf
);

  state_t state_q;
  state_t state_d;

  logic [SEG_W-1:0]  tens_q;
  logic [SEG_W-1:0]  ones_q;
  logic [SEG_W-1:0]  tens_n;
  logic [SEG_W-1:0]  ones_n;
  logic [3:0]        tens_dig;
  logic [3:0]        ones_dig;
  logic              tens_ok;
  logic              ones_ok;
  dd_t               dd_q;
  logic [ITER_W-1:0] iter_q;
  logic              bad_q;
  logic [BIN_W-1:0]  bin_q;
  logic              err_q;
  logic              ovf_q;
  logic              last_iter;
  logic [BIN_W-1:0]  dd_bin;

`ifdef SEG_ACTIVE_HIGH_EN
  assign tens_n = ~tens_q;
  assign ones_n = ~ones_q;
`else
  assign tens_n = tens_q;
  assign ones_n = ones_q;
`endif

  seg_pattern_decoder u_tens (
    .pattern (tens_n),
    .digit   (tens_dig),
    .legal   (tens_ok)
  );

  seg_pattern_decoder u_ones (
    .pattern (ones_n),
    .digit   (ones_dig),
    .legal   (ones_ok)
  );

  assign last_iter = (iter_q == ITER_W'(ITERS));
  assign dd_bin    = dd_q[BIN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = DECODE;
      DECODE:  state_d = CONVERT;
      CONVERT: if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= '0;
      ones_q <= '0;
      dd_q   <= '0;
      iter_q <= '0;
      bad_q  <= 1'b0;
      bin_q  <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            tens_q <= seg_tens;
            ones_q <= seg_ones;
          end
        end
        DECODE: begin
          dd_q   <= {tens_dig, ones_dig, {BIN_W{1'b0}}};
          bad_q  <= ~(tens_ok & ones_ok);
          iter_q <= '0;
        end
        CONVERT: begin
          if (!last_iter) begin
            dd_q   <= dabble_step(dd_q);
            iter_q <= iter_q + 1'b1;
          end else begin
            // Illegal input still walks the full path, result masked here
            bin_q <= bad_q ? '0 : dd_bin;
            err_q <= bad_q;
            ovf_q <= !bad_q && (dd_bin > BIN_W'(CNT_MAX));
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin       = bin_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seven_segments_to_binary.sv
// Self-checking bench for seven_segments_to_binary.
// Honours SEG_ACTIVE_HIGH_EN by inverting driven patterns.
module tb_seven_segments_to_binary;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [6:0] seg_ones = '0;
  logic [6:0] seg_tens = '0;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] bin;
  logic       err;
  logic       ovf;

  int checks = 0;
  int passes = 0;

  logic [6:0] pats [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  always #5 clk = ~clk;

  seven_segments_to_binary dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seg_ones  (seg_ones),
    .seg_tens  (seg_tens),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err),
    .ovf       (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  function automatic logic [6:0] drv(input logic [6:0] p);
`ifdef SEG_ACTIVE_HIGH_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (pats[i] == p) return i;
    return -1;
  endfunction

  // Reference: decimal value of the pair, flags from plain arithmetic
  function automatic void model(input logic [6:0] t,
                                input logic [6:0] o,
                                output int eb,
                                output int ee,
                                output int ev);
    int dt;
    int d1;
    dt = lookup(t);
    d1 = lookup(o);
    if (dt < 0 || d1 < 0) begin
      eb = 0; ee = 1; ev = 0;
    end else begin
      eb = dt * 10 + d1;
      ee = 0;
      ev = (eb > 63) ? 1 : 0;
    end
  endfunction

  task automatic run(input logic [6:0] t,
                     input logic [6:0] o,
                     input int hold);
    int eb, ee, ev, cyc;
    model(t, o, eb, ee, ev);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("in_ready_idle", in_ready, 1);
    seg_tens  = drv(t);
    seg_ones  = drv(o);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    // junk while busy must be ignored
    seg_tens = 7'($urandom);
    seg_ones = 7'($urandom);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!out_valid && cyc < 20);
    in_valid = 1'b0;
    chk("latency", cyc, 9);
    chk("bin", bin, eb);
    chk("err", err, ee);
    chk("ovf", ovf, ev);
    chk("in_ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_bin", bin, eb);
      chk("hold_err", err, ee);
      chk("hold_ovf", ovf, ev);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_valid", out_valid, 0);
    chk("handoff_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    logic [6:0] rt, ro;

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin", bin, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(pats[3], pats[1], 0);
    run(pats[6], pats[3], 0);
    run(pats[9], pats[9], 5);

    // reset mid-conversion
    seg_tens = drv(pats[5]);
    seg_ones = drv(pats[5]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_bin", bin, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_partial", seen, 0);
    run(pats[1], pats[0], 0);

    run(7'b1111111, pats[7], 0);
    run(pats[4], pats[2], 0);
    run(pats[0], pats[0], 1);

    for (int n = 0; n < 16; n++) begin
      rt = ($urandom_range(0, 4) == 0) ? 7'($urandom)
                                        : pats[$urandom_range(0, 9)];
      ro = ($urandom_range(0, 4) == 0) ? 7'($urandom)
                                        : pats[$urandom_range(0, 9)];
      run(rt, ro, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seven_segments_to_binary.md
SEVEN_SEGMENTS_TO_BINARY -- requirements
Module: seven_segments_to_binary

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  input  1  source presents a digit pair.
REQ-004 SHALL have ports: in_ready  output  1  block accepts a pair this cycle.
REQ-005 SHALL have ports: seg_ones  input  7  ones-digit pattern {g,f,e,d,c,b,a}.
REQ-006 SHALL have ports: seg_tens  input  7  tens-digit pattern {g,f,e,d,c,b,a}.
REQ-007 SHALL have ports: out_valid  output  1  result held and valid.
REQ-008 SHALL have ports: out_ready  input  1  sink takes the result.
REQ-009 SHALL have ports: bin  output  7  binary value, 0..99.
REQ-010 SHALL have ports: err  output  1  at least one pattern not a legal digit.
REQ-011 SHALL have ports: ovf  output  1  value exceeds 63, i.e. outside 6-bit counter range.

Function
REQ-012 SHALL use the active-low digit patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other pattern is illegal.
REQ-013 SHALL use states IDLE, DECODE, CONVERT and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL accept a pair on an edge where in_valid and in_ready are both 1, register both patterns, and go to DECODE.
REQ-016 DECODE SHALL map both patterns to an 8-bit BCD word {tens,ones} in one cycle, latch err, then go to CONVERT with iteration count 0.
REQ-017 CONVERT SHALL run reverse double-dabble for exactly 7 cycles; each cycle shifts {bcd,bin} right by 1, then subtracts 3 from every BCD nibble that is >= 8.
REQ-018 After the 7th iteration, CONVERT SHALL go to DONE.
REQ-019 On an illegal pattern, the block SHALL still take the full path (constant latency), force bin=0 and ovf=0, and set err=1.
REQ-020 out_valid SHALL be 1 only in DONE and SHALL rise exactly 9 cycles after the accepting edge.
REQ-021 bin, err and ovf SHALL stay stable while out_valid=1.
REQ-022 DONE SHALL hold while out_ready=0 and SHALL return to IDLE on an edge with out_ready=1.
REQ-023 in_ready SHALL go high on the cycle after that return; a back-to-back pair is never accepted in the same cycle as result handoff.
REQ-024 in_valid SHALL be ignored outside IDLE; no queueing.
REQ-025 ovf SHALL be 1 iff err=0 and bin > 63.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, bin=0, err=0, ovf=0 and clear the iteration count, from any state including mid-CONVERT.
REQ-027 After rst_n deasserts, no partial result SHALL appear; the first out_valid follows a new accepted pair.

Configuration
REQ-028 With SEG_ACTIVE_HIGH_EN defined, both segment inputs SHALL be inverted before decode (active-high displays); without it, inputs SHALL be treated as active-low per REQ-012.
REQ-029 The macro SHALL NOT change latency, handshake or output encoding.

Structure
REQ-030 Package seven_seg_pkg SHALL hold the ten digit-pattern constants, the state enum, and the width constants (SEG_W=7, BCD_W=8, BIN_W=7, CNT_MAX=63).
REQ-031 Sub-module seg_pattern_decoder SHALL map one 7-bit pattern to a 4-bit digit plus a legal flag, combinationally; it SHALL be instantiated twice (tens, ones).

Verification
REQ-032 Bench SHALL drive tens=0110000 (3) and ones=1111001 (1) -> 9 cycles after acceptance, bin=31, err=0, ovf=0.
REQ-033 Bench SHALL drive tens=0000010 (6) and ones=0110000 (3) -> bin=63, ovf=0; then tens=0010000 (9) and ones=0010000 (9) -> bin=99, ovf=1.
REQ-034 Bench SHALL drive tens=1111111 (blank) and ones=1111000 (7) -> out_valid at cycle 9, err=1, bin=0, ovf=0.
REQ-035 Bench SHALL hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready stays 0; raising out_ready -> IDLE next edge.
REQ-036 Bench SHALL pulse rst_n low during the 4th CONVERT cycle -> all outputs go to reset values at once; the next pair 1,0 -> bin=10.
REQ-037 Bench SHALL run with SEG_ACTIVE_HIGH_EN and inverted patterns for 4,2 (1100110, 1011011) -> bin=42, err=0.
